// File: rtl/fp16_pkg.sv
// Shared FP16 datapath widths and the unpacked-operand record used between stages.
package fp16_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP16_SIG_W  = 11;
    localparam int FP16_BIAS   = 15;
    localparam int LZ_W        = 4;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

endpackage

// File: rtl/left_shifter_10.sv
// Zero-filling left shift of a 10-bit fraction; amounts of 10 or more clear the result.
module left_shifter_10
    import fp16_pkg::*;
(
    input  logic [FP16_FRAC_W-1:0] in,
    input  logic [LZ_W-1:0]        shift_amt,
    output logic [FP16_FRAC_W-1:0] out
);

    assign out = in << shift_amt;

endmodule

// File: rtl/lzc_11.sv
// Combinational leading-zero count of an 11-bit significand; all-zero gives 11.
module lzc_11
    import fp16_pkg::*;
(
    input  logic [FP16_SIG_W-1:0] sig,
    output logic [LZ_W-1:0]       lz
);

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        lz = LZ_W'(FP16_SIG_W);
        // Scan upward so the most significant set bit is the last (winning) assignment.
        for (int i = 0; i < FP16_SIG_W; i++) begin
            if (sig[i]) begin
                lz = LZ_W'(FP16_SIG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_norm_stage.sv
// Two-register normalization stage: leading-zero count in S1, shift and exponent clamp into S2.
module fp16_norm_stage
    import fp16_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [FP16_EXP_W-1:0]  in_exp,
    input  logic [FP16_SIG_W-1:0]  in_sig,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [FP16_EXP_W-1:0]  out_exp,
    output logic [FP16_FRAC_W-1:0] out_frac,
    output logic                   out_zero,
    output logic                   out_sub
);

    logic                   v1, v2;
    logic                   s1_sign;
    logic [FP16_EXP_W-1:0]  s1_exp;
    logic [FP16_SIG_W-1:0]  s1_sig;
    logic [LZ_W-1:0]        s1_lz;
    logic [LZ_W-1:0]        in_lz;

    fp16_t                  s2_op;
    logic                   s2_zero, s2_sub;

    logic                   adv2, load;
    logic [FP16_EXP_W-1:0]  e_m1;
    logic [LZ_W-1:0]        shift;
    logic [FP16_FRAC_W-1:0] sh;
    logic                   lead;
    fp16_t                  nxt_op;
    logic                   nxt_zero, nxt_sub;

    assign adv2     = v1 && (!v2 || out_ready);
    assign in_ready = !v1 || adv2;
    assign load     = in_valid && in_ready;

    lzc_11 u_lzc (
        .sig (in_sig),
        .lz  (in_lz)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_sig  <= '0;
            s1_lz   <= '0;
        end else begin
            if (load) begin
                v1      <= 1'b1;
                s1_sign <= in_sign;
                s1_exp  <= (in_exp == '0) ? FP16_EXP_W'(1) : in_exp;
                s1_sig  <= in_sig;
                s1_lz   <= in_lz;
            end else if (adv2) begin
                v1 <= 1'b0;
            end

            if (adv2) begin
                v2 <= 1'b1;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    // Shift is capped at e-1 so the exponent never drops below the subnormal field value of 1.
    assign e_m1  = s1_exp - FP16_EXP_W'(1);
    assign shift = ({1'b0, s1_lz} < e_m1) ? s1_lz : e_m1[LZ_W-1:0];
    // For a nonzero significand the leading one reaches the hidden slot exactly when unclamped.
    assign lead  = (shift == s1_lz);

    left_shifter_10 u_shift (
        .in        (s1_sig[FP16_FRAC_W-1:0]),
        .shift_amt (shift),
        .out       (sh)
    );

    always_comb begin
        nxt_op.sign = s1_sign;
        nxt_op.exp  = '0;
        nxt_op.frac = sh;
        nxt_zero    = 1'b0;
        nxt_sub     = 1'b0;
        if (s1_sig == '0) begin
            nxt_op.frac = '0;
            nxt_zero    = 1'b1;
        end else if (lead) begin
            nxt_op.exp = s1_exp - {1'b0, shift};
        end else begin
            nxt_sub = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_op   <= '0;
            s2_zero <= 1'b0;
            s2_sub  <= 1'b0;
        end else if (adv2) begin
            s2_op   <= nxt_op;
            s2_zero <= nxt_zero;
            s2_sub  <= nxt_sub;
        end
    end

    assign out_valid = v2;
    assign out_sign  = s2_op.sign;
    assign out_exp   = s2_op.exp;
    assign out_frac  = s2_op.frac;
    assign out_zero  = s2_zero;
    assign out_sub   = s2_sub;

endmodule

// File: tb/tb_fp16_norm_stage.sv
// Directed bench for fp16_norm_stage: encodings, latency, backpressure, throughput and reset.
module tb_fp16_norm_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [10:0] in_sig;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [4:0]  out_exp;
    logic [9:0]  out_frac;
    logic        out_zero;
    logic        out_sub;

    int n_checks = 0;
    int n_bad    = 0;

    // Stream beats: {sign, exp, sig} in, {sign, exp, frac, zero, sub} expected.
    logic [16:0] beat_in  [4];
    logic [17:0] beat_exp [4];

    fp16_norm_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_zero  (out_zero),
        .out_sub   (out_sub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [17:0] out_word();
        return {out_sign, out_exp, out_frac, out_zero, out_sub};
    endfunction

    // One beat through an idle pipe with out_ready high; checks the 2-cycle latency and result.
    task automatic run_vec(input string tag, input logic sign, input logic [4:0] exp,
                           input logic [10:0] sig, input logic [17:0] want);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = sign;
        in_exp    = exp;
        in_sig    = sig;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_word(), want);
    endtask

    task automatic run_stream(input string tag, input int stall_lo, input int stall_hi);
        int          sent;
        int          rcvd;
        logic [17:0] snap;
        logic [17:0] rx     [4];
        int          rx_cyc [4];
        sent = 0;
        rcvd = 0;
        snap = '0;
        for (int c = 0; c < 40 && rcvd < 4; c++) begin
            @(negedge clk);
            out_ready = !(c >= stall_lo && c < stall_hi);
            #1;
            if (stall_hi > stall_lo) begin
                if (c == stall_lo + 2) begin
                    check({tag, "_full_in_ready"}, in_ready, 0);
                    check({tag, "_full_out_valid"}, out_valid, 1);
                    snap = out_word();
                end else if (c > stall_lo + 2 && c < stall_hi) begin
                    check({tag, "_hold"}, out_word(), snap);
                end
            end
            if (out_valid && out_ready) begin
                rx[rcvd]     = out_word();
                rx_cyc[rcvd] = c;
                rcvd++;
            end
            if (sent < 4) begin
                in_valid = 1'b1;
                {in_sign, in_exp, in_sig} = beat_in[sent];
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check({tag, "_rx_count"}, rcvd, 4);
        for (int i = 0; i < rcvd; i++) begin
            check($sformatf("%s_beat%0d", tag, i), rx[i], beat_exp[i]);
            if (stall_hi <= stall_lo) check($sformatf("%s_cycle%0d", tag, i), rx_cyc[i], 2 + i);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_no_dup"}, out_valid, 0);
    endtask

    initial begin
        int saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sig    = '0;
        out_ready = 1'b0;

        // Pass-through beats plus one normalizing beat, all hand-computed.
        beat_in[0]  = {1'b0, 5'd3,  11'h401};  beat_exp[0] = {1'b0, 5'd3,  10'h001, 2'b00};
        beat_in[1]  = {1'b1, 5'd20, 11'h0A5};  beat_exp[1] = {1'b1, 5'd17, 10'h128, 2'b00};
        beat_in[2]  = {1'b0, 5'd11, 11'h423};  beat_exp[2] = {1'b0, 5'd11, 10'h023, 2'b00};
        beat_in[3]  = {1'b1, 5'd15, 11'h434};  beat_exp[3] = {1'b1, 5'd15, 10'h034, 2'b00};

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data", out_word(), 0);
        #12;
        rst = 1'b0;

        run_vec("normalize",  1'b1, 5'd20, 11'h0A5, {1'b1, 5'd17, 10'h128, 2'b00});
        run_vec("edge_exp1",  1'b0, 5'd9,  11'h005, {1'b0, 5'd1,  10'h100, 2'b00});
        run_vec("passthru",   1'b0, 5'd30, 11'h4AB, {1'b0, 5'd30, 10'h0AB, 2'b00});
        run_vec("clamp",      1'b0, 5'd4,  11'h005, {1'b0, 5'd0,  10'h028, 2'b01});
        run_vec("exp0",       1'b1, 5'd0,  11'h005, {1'b1, 5'd0,  10'h005, 2'b01});
        run_vec("zero",       1'b0, 5'd17, 11'h000, {1'b0, 5'd0,  10'h000, 2'b10});

        run_stream("bp", 0, 5);
        run_stream("tput", 0, 0);

        // Fill both stages, then reset asynchronously in mid-cycle.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        {in_sign, in_exp, in_sig} = beat_in[0];
        @(negedge clk);
        {in_sign, in_exp, in_sig} = beat_in[1];
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_full_valid", out_valid, 1);
        check("pre_rst_full_ready", in_ready, 0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        saw_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) saw_valid++;
        end
        check("post_rst_no_stale", saw_valid, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
